// File: rtl/dram_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_access_pkg
// Purpose  : Shared definitions for the MEM/WB data-SRAM access unit:
//            load/store encodings, the issue FSM state type and the datapath
//            width.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package dram_access_pkg;

  localparam int DATA_W = 32;

  // load_store_mem encodings; bit 2 marks a store, bits [1:0] the size
  localparam logic [2:0] LS_NONE = 3'b000;
  localparam logic [2:0] LS_B    = 3'b001;
  localparam logic [2:0] LS_H    = 3'b010;
  localparam logic [2:0] LS_W    = 3'b011;
  localparam logic [2:0] LS_SB   = 3'b101;
  localparam logic [2:0] LS_SH   = 3'b110;
  localparam logic [2:0] LS_SW   = 3'b111;

  // size field values (load_store_mem[1:0])
  localparam logic [1:0] SZ_B = 2'b01;
  localparam logic [1:0] SZ_H = 2'b10;
  localparam logic [1:0] SZ_W = 2'b11;

  // IDLE: free to issue; DONE: access already issued for a stalled instruction
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage : dram_access_pkg
`default_nettype wire

// File: rtl/dram_access_if.sv
`default_nettype none
// ============================================================================
// Module   : dram_access_if
// Purpose  : Bundle of MEM-stage request, data-SRAM and WB-result signals
//            around dram_access.
// Modports : slave  - the dram_access unit
//            master - pipeline/SRAM environment driving it
// Options  : DRAM_ALIGN_CHECK_EN adds adel_mem / ades_mem
// Revision : 1.0  initial release
// ============================================================================
interface dram_access_if;
  import dram_access_pkg::*;

  // MEM-stage request
  logic              mem_valid;
  logic              stall_mem;
  logic              stall_wb;
  logic [2:0]        load_store_mem;
  logic              load_unsigned_mem;
  logic [DATA_W-1:0] addr_mem;
  logic [DATA_W-1:0] store_data_mem;
  logic [3:0]        mode_mem;
  logic              addr_illegal_mem;
  // data SRAM
  logic              data_sram_en;
  logic [3:0]        data_sram_wen;
  logic [DATA_W-1:0] data_sram_addr;
  logic [DATA_W-1:0] data_sram_wdata;
  logic [DATA_W-1:0] data_sram_rdata;
  // WB result
  logic [DATA_W-1:0] load_data_wb;
  logic              load_valid_wb;
`ifdef DRAM_ALIGN_CHECK_EN
  logic              adel_mem;
  logic              ades_mem;

  modport slave (
    input  mem_valid, stall_mem, stall_wb, load_store_mem, load_unsigned_mem,
           addr_mem, store_data_mem, mode_mem, addr_illegal_mem, data_sram_rdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
           load_data_wb, load_valid_wb, adel_mem, ades_mem
  );

  modport master (
    output mem_valid, stall_mem, stall_wb, load_store_mem, load_unsigned_mem,
           addr_mem, store_data_mem, mode_mem, addr_illegal_mem, data_sram_rdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
           load_data_wb, load_valid_wb, adel_mem, ades_mem
  );
`else
  modport slave (
    input  mem_valid, stall_mem, stall_wb, load_store_mem, load_unsigned_mem,
           addr_mem, store_data_mem, mode_mem, addr_illegal_mem, data_sram_rdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
           load_data_wb, load_valid_wb
  );

  modport master (
    output mem_valid, stall_mem, stall_wb, load_store_mem, load_unsigned_mem,
           addr_mem, store_data_mem, mode_mem, addr_illegal_mem, data_sram_rdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
           load_data_wb, load_valid_wb
  );
`endif

endinterface : dram_access_if
`default_nettype wire

// File: rtl/dram_access_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Selects the addressed byte/half/word out of an SRAM read word
//            and sign- or zero-extends it to the full width.
// Ports    : i_off      byte offset within the word
//            i_size     01 byte, 10 half, 11 word
//            i_unsigned 1 = zero-extend
//            i_word     raw SRAM read word
//            o_data     extended load value
// Revision : 1.0  initial release
// ============================================================================
module load_extend
  import dram_access_pkg::*;
(
  input  wire logic [1:0]        i_off,
  input  wire logic [1:0]        i_size,
  input  wire logic              i_unsigned,
  input  wire logic [DATA_W-1:0] i_word,
  output logic      [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase

    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    case (i_size)
      SZ_B:    o_data = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    o_data = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule : load_extend
`default_nettype wire

// File: rtl/dram_access.sv
`default_nettype none
// ============================================================================
// Module   : dram_access
// Purpose  : MEM/WB data-SRAM access unit. Issues one SRAM request in the
//            first MEM cycle of each memory instruction, replicates store
//            data, captures the 1-cycle read response and presents the
//            extended load result to WB, held stable across WB stalls.
// Ports    : clk, rst      clock, synchronous active-high reset
//            bus (slave)   MEM request, data SRAM, WB result signals
// Params   : DATA_W        data/address width (32)
//            SRAM_LAT      SRAM read latency, only 1 is accepted
// Options  : DRAM_ALIGN_CHECK_EN  adds misalignment suppression and the
//                                 adel_mem / ades_mem outputs
// Revision : 1.0  initial release
// ============================================================================
module dram_access
  import dram_access_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SRAM_LAT = 1
)(
  input  wire logic   clk,
  input  wire logic   rst,
  dram_access_if.slave bus
);

  // The response pipeline assumes the read word arrives exactly one cycle
  // after the request.
  generate
    if (SRAM_LAT != 1) begin : g_bad_lat
      $error("dram_access: SRAM_LAT must be 1");
    end
  endgenerate

  state_t            r_state;
  logic [1:0]        r_resp_off;
  logic [1:0]        r_resp_size;
  logic              r_resp_unsigned;
  logic              r_resp_pending;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_valid;
  logic              r_wb_load;

  logic              w_is_ls;
  logic              w_is_store;
  logic              w_is_load;
  logic [1:0]        w_size;
  logic              w_suppress;
  logic              w_acc;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_ext;

  assign w_is_ls    = (bus.load_store_mem != LS_NONE);
  assign w_is_store = bus.load_store_mem[2];
  assign w_is_load  = w_is_ls & ~w_is_store;
  assign w_size     = bus.load_store_mem[1:0];

`ifdef DRAM_ALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = ((w_size == SZ_H) & bus.addr_mem[0]) |
                      ((w_size == SZ_W) & (bus.addr_mem[1:0] != 2'b00));
  assign w_suppress = bus.addr_illegal_mem | w_misalign;
  assign bus.adel_mem = ~rst & bus.mem_valid & w_is_load  & w_misalign;
  assign bus.ades_mem = ~rst & bus.mem_valid & w_is_store & w_misalign;
`else
  assign w_suppress = bus.addr_illegal_mem;
`endif

  // DONE blocks re-issue while the same instruction sits stalled in MEM.
  assign w_acc = ~rst & bus.mem_valid & w_is_ls & ~w_suppress & (r_state != DONE);

  always_comb begin
    w_wdata = '0;
    case (bus.load_store_mem)
      LS_SB:   w_wdata = {4{bus.store_data_mem[7:0]}};
      LS_SH:   w_wdata = {2{bus.store_data_mem[15:0]}};
      LS_SW:   w_wdata = bus.store_data_mem;
      default: w_wdata = '0;
    endcase
  end

  assign bus.data_sram_en    = w_acc;
  assign bus.data_sram_wen   = (w_acc & w_is_store) ? bus.mode_mem : 4'b0000;
  assign bus.data_sram_addr  = w_acc ? {bus.addr_mem[DATA_W-1:2], 2'b00} : '0;
  assign bus.data_sram_wdata = (w_acc & w_is_store) ? w_wdata : '0;

  // Single extractor: its output is both the live WB value in the response
  // cycle and the value captured into the hold register.
  load_extend u_load_extend (
    .i_off      (r_resp_off),
    .i_size     (r_resp_size),
    .i_unsigned (r_resp_unsigned),
    .i_word     (bus.data_sram_rdata),
    .o_data     (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_resp_off      <= 2'b00;
      r_resp_size     <= 2'b00;
      r_resp_unsigned <= 1'b0;
      r_resp_pending  <= 1'b0;
      r_hold          <= '0;
      r_hold_valid    <= 1'b0;
      r_wb_load       <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (w_acc & bus.stall_mem) r_state <= DONE;
        DONE:    if (~bus.stall_mem)        r_state <= IDLE;
        default:                            r_state <= IDLE;
      endcase

      r_resp_pending <= w_acc & ~w_is_store;
      if (w_acc & ~w_is_store) begin
        r_resp_off      <= bus.addr_mem[1:0];
        r_resp_size     <= w_size;
        r_resp_unsigned <= bus.load_unsigned_mem;
      end

      // Keep the response only if its load is not leaving WB this cycle;
      // otherwise the live path already delivered it.
      if (r_resp_pending) begin
        r_hold       <= w_ext;
        r_hold_valid <= ~(r_wb_load & ~bus.stall_wb);
      end else if (r_wb_load & ~bus.stall_wb) begin
        r_hold_valid <= 1'b0;
      end

      // A load enters WB when it leaves MEM unsuppressed.
      if (~bus.stall_wb) begin
        r_wb_load <= bus.mem_valid & ~bus.stall_mem & w_is_load & ~w_suppress;
      end
    end
  end

  assign bus.load_valid_wb = r_wb_load;
  assign bus.load_data_wb  = r_wb_load ? (r_hold_valid ? r_hold : w_ext) : '0;

endmodule : dram_access
`default_nettype wire

// File: tb/tb_dram_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_access
// Purpose  : Directed self-checking bench for dram_access.
// Revision : 1.0  initial release
// ============================================================================
module tb_dram_access;
  import dram_access_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dram_access_if bus ();

  dram_access #(.DATA_W(32), .SRAM_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_valid         = 1'b0;
    bus.stall_mem         = 1'b0;
    bus.stall_wb          = 1'b0;
    bus.load_store_mem    = LS_NONE;
    bus.load_unsigned_mem = 1'b0;
    bus.addr_mem          = 32'h0;
    bus.store_data_mem    = 32'h0;
    bus.mode_mem          = 4'h0;
    bus.addr_illegal_mem  = 1'b0;
  endtask

  task automatic req(input logic [2:0] ls, input logic uns, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] mode);
    bus.mem_valid         = 1'b1;
    bus.load_store_mem    = ls;
    bus.load_unsigned_mem = uns;
    bus.addr_mem          = addr;
    bus.store_data_mem    = data;
    bus.mode_mem          = mode;
  endtask

  initial begin
    idle();
    bus.data_sram_rdata = 32'h0;
    rst = 1'b1;
    tick();
    tick();
    // request presented during reset must not reach the SRAM
    req(LS_SW, 1'b0, 32'h1004, 32'hDEADBEEF, 4'hF);
    #1;
    chk("rst_en",    32'(bus.data_sram_en), 32'h0);
    chk("rst_wen",   32'(bus.data_sram_wen), 32'h0);
    chk("rst_valid", 32'(bus.load_valid_wb), 32'h0);
    chk("rst_data",  bus.load_data_wb, 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    tick();
    idle();
    rst = 1'b0;

    // sw: single-cycle word write
    tick();
    req(LS_SW, 1'b0, 32'h1004, 32'hDEADBEEF, 4'hF);
    #1;
    chk("sw_en",    32'(bus.data_sram_en), 32'h1);
    chk("sw_wen",   32'(bus.data_sram_wen), 32'hF);
    chk("sw_addr",  bus.data_sram_addr, 32'h1004);
    chk("sw_wdata", bus.data_sram_wdata, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("sw_en_off",   32'(bus.data_sram_en), 32'h0);
    chk("sw_no_valid", 32'(bus.load_valid_wb), 32'h0);
    chk("sw_no_data",  bus.load_data_wb, 32'h0);

    // sb: byte replicated, word-aligned address
    tick();
    req(LS_SB, 1'b0, 32'h1003, 32'h12345678, 4'h8);
    #1;
    chk("sb_wdata", bus.data_sram_wdata, 32'h78787878);
    chk("sb_wen",   32'(bus.data_sram_wen), 32'h8);
    chk("sb_addr",  bus.data_sram_addr, 32'h1000);

    // lb followed back-to-back by lbu at another offset
    tick();
    req(LS_B, 1'b0, 32'h2002, 32'h0, 4'h0);
    #1;
    chk("lb_en",    32'(bus.data_sram_en), 32'h1);
    chk("lb_wen",   32'(bus.data_sram_wen), 32'h0);
    chk("lb_wdata", bus.data_sram_wdata, 32'h0);
    tick();
    req(LS_B, 1'b1, 32'h2001, 32'h0, 4'h0);
    bus.data_sram_rdata = 32'h00F00000;
    #1;
    chk("lb_valid", 32'(bus.load_valid_wb), 32'h1);
    chk("lb_data",  bus.load_data_wb, 32'hFFFFFFF0);
    tick();
    idle();
    bus.data_sram_rdata = 32'h0000AB00;
    #1;
    chk("lbu1_data", bus.load_data_wb, 32'h000000AB);
    tick();
    bus.data_sram_rdata = 32'h0;
    #1;
    chk("ld_gone_valid", 32'(bus.load_valid_wb), 32'h0);
    chk("ld_gone_data",  bus.load_data_wb, 32'h0);

    // lbu offset 2
    req(LS_B, 1'b1, 32'h2002, 32'h0, 4'h0);
    tick();
    idle();
    bus.data_sram_rdata = 32'h00F00000;
    #1;
    chk("lbu_data", bus.load_data_wb, 32'h000000F0);

    // lhu and lh upper half
    tick();
    req(LS_H, 1'b1, 32'h2002, 32'h0, 4'h0);
    tick();
    req(LS_H, 1'b0, 32'h2002, 32'h0, 4'h0);
    bus.data_sram_rdata = 32'h80010000;
    #1;
    chk("lhu_data", bus.load_data_wb, 32'h00008001);
    tick();
    idle();
    #1;
    chk("lh_data", bus.load_data_wb, 32'hFFFF8001);

    // sh stalled in MEM for 3 cycles: exactly one request
    tick();
    req(LS_SH, 1'b0, 32'h1002, 32'h0000BEEF, 4'hC);
    bus.stall_mem = 1'b1;
    #1;
    chk("sh_en_first", 32'(bus.data_sram_en), 32'h1);
    chk("sh_wdata",    bus.data_sram_wdata, 32'hBEEFBEEF);
    chk("sh_wen",      32'(bus.data_sram_wen), 32'hC);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sh_en_stall", 32'(bus.data_sram_en), 32'h0);
      chk("sh_state_done", 32'(dut.r_state), 32'(DONE));
    end
    tick();
    bus.stall_mem = 1'b0;
    #1;
    chk("sh_en_release", 32'(bus.data_sram_en), 32'h0);
    chk("sh_state_release", 32'(dut.r_state), 32'(DONE));
    tick();
    idle();
    #1;
    chk("sh_state_idle", 32'(dut.r_state), 32'(IDLE));

    // lw held across a 4-cycle WB stall while rdata changes
    req(LS_W, 1'b0, 32'h2000, 32'h0, 4'h0);
    tick();
    idle();
    bus.stall_wb  = 1'b1;
    bus.stall_mem = 1'b1;
    bus.data_sram_rdata = 32'hCAFEF00D;
    #1;
    chk("lw_live_valid", 32'(bus.load_valid_wb), 32'h1);
    chk("lw_live_data",  bus.load_data_wb, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.data_sram_rdata = 32'h0;
      #1;
      chk("lw_hold_data", bus.load_data_wb, 32'hCAFEF00D);
    end
    tick();
    bus.stall_wb  = 1'b0;
    bus.stall_mem = 1'b0;
    #1;
    chk("lw_release_data",  bus.load_data_wb, 32'hCAFEF00D);
    chk("lw_release_valid", 32'(bus.load_valid_wb), 32'h1);
    tick();
    chk("lw_left_valid", 32'(bus.load_valid_wb), 32'h0);

    // lw stalled in MEM: response captured, shown on arrival in WB
    req(LS_W, 1'b0, 32'h2004, 32'h0, 4'h0);
    bus.stall_mem = 1'b1;
    #1;
    chk("lws_en", 32'(bus.data_sram_en), 32'h1);
    tick();
    bus.data_sram_rdata = 32'h11223344;
    #1;
    chk("lws_en_stall", 32'(bus.data_sram_en), 32'h0);
    chk("lws_not_wb",   32'(bus.load_valid_wb), 32'h0);
    tick();
    bus.stall_mem = 1'b0;
    bus.data_sram_rdata = 32'h0;
    tick();
    idle();
    #1;
    chk("lws_valid", 32'(bus.load_valid_wb), 32'h1);
    chk("lws_data",  bus.load_data_wb, 32'h11223344);
    tick();
    chk("lws_left", 32'(bus.load_valid_wb), 32'h0);

    // illegal address: no request, FSM stays IDLE even when stalled
    req(LS_W, 1'b0, 32'h2008, 32'h0, 4'h0);
    bus.addr_illegal_mem = 1'b1;
    bus.stall_mem = 1'b1;
    #1;
    chk("ill_en", 32'(bus.data_sram_en), 32'h0);
    tick();
    chk("ill_state", 32'(dut.r_state), 32'(IDLE));
    bus.stall_mem = 1'b0;
    tick();
    idle();
    #1;
    chk("ill_valid", 32'(bus.load_valid_wb), 32'h0);

    // misaligned word access
    tick();
    req(LS_W, 1'b0, 32'h3002, 32'h0, 4'h0);
    #1;
`ifdef DRAM_ALIGN_CHECK_EN
    chk("mis_lw_adel", 32'(bus.adel_mem), 32'h1);
    chk("mis_lw_ades", 32'(bus.ades_mem), 32'h0);
    chk("mis_lw_en",   32'(bus.data_sram_en), 32'h0);
    tick();
    req(LS_SH, 1'b0, 32'h3001, 32'h0, 4'h3);
    #1;
    chk("mis_sh_ades", 32'(bus.ades_mem), 32'h1);
    chk("mis_sh_en",   32'(bus.data_sram_en), 32'h0);
`else
    chk("mis_lw_en",   32'(bus.data_sram_en), 32'h1);
    chk("mis_lw_addr", bus.data_sram_addr, 32'h3000);
`endif
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dram_access
`default_nettype wire
